// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream for fifo_stream_reader.
// master = the drain engine, slave = FIFO/consumer environment.
interface fifo_stream_reader_if #(
   parameter int unsigned D_WIDTH = 48
);
   logic               i_fifo_empty;
   logic [D_WIDTH-1:0] i_fifo_data;
   logic               o_fifo_rd_en;
   logic               o_m_valid;
   logic               i_m_ready;
   logic [D_WIDTH-1:0] o_m_data;
   logic               o_m_last;

   modport master (
      input  i_fifo_empty, i_fifo_data, i_m_ready,
      output o_fifo_rd_en, o_m_valid, o_m_data, o_m_last
   );

   modport slave (
      output i_fifo_empty, i_fifo_data, i_m_ready,
      input  o_fifo_rd_en, o_m_valid, o_m_data, o_m_last
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream via a 3-entry skid buffer.
// Define FIFO_RD_LAST_EN to build the PKT_LEN beat counter driving o_m_last.
module fifo_stream_reader #(
   parameter int unsigned D_WIDTH = 48,
   parameter int unsigned PKT_LEN = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   fifo_stream_reader_if.master bus,
   output logic [1:0]           o_buf_cnt
);
   localparam int unsigned DEPTH = 3;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = 3;

   if (PKT_LEN < 2 || PKT_LEN > 65535) begin : g_bad_pkt_len
      $error("fifo_stream_reader: PKT_LEN must be within 2..65535");
   end

   logic [D_WIDTH-1:0] buf_q [0:DEPTH-1];
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_idx;
   logic [1:0]         buf_cnt;
   logic               inflight;
   logic [CNT_W-1:0]   occ_c;
   logic               pop_c;
   logic               xfer_c;

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
   endfunction

   // Pop decision uses only registered occupancy, so i_m_ready never reaches o_fifo_rd_en.
   always_comb begin
      occ_c  = CNT_W'(buf_cnt) + CNT_W'(inflight);
      pop_c  = i_rst_n & ~bus.i_fifo_empty & (occ_c < CNT_W'(DEPTH));
      xfer_c = (buf_cnt != 2'd0) & bus.i_m_ready;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         buf_cnt  <= '0;
         inflight <= 1'b0;
         wr_idx   <= '0;
         rd_idx   <= '0;
      end else begin
         inflight <= pop_c;
         if (inflight) wr_idx <= idx_inc(wr_idx);
         if (xfer_c)   rd_idx <= idx_inc(rd_idx);
         buf_cnt <= 2'(CNT_W'(buf_cnt) + CNT_W'(inflight) - CNT_W'(xfer_c));
      end
   end

   // Storage is reset so o_m_data reads 0 while held in reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= '0;
      end else if (inflight) begin
         buf_q[wr_idx] <= bus.i_fifo_data;
      end
   end

   assign bus.o_fifo_rd_en = pop_c;
   assign bus.o_m_valid    = (buf_cnt != 2'd0);
   assign bus.o_m_data     = buf_q[rd_idx];
   assign o_buf_cnt        = buf_cnt;

`ifdef FIFO_RD_LAST_EN
   logic [15:0] beat_cnt;
   logic        last_c;

   assign last_c = (buf_cnt != 2'd0) & (beat_cnt == 16'(PKT_LEN - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         beat_cnt <= '0;
      end else if (xfer_c) begin
         beat_cnt <= last_c ? 16'd0 : beat_cnt + 16'd1;
      end
   end

   assign bus.o_m_last = last_c;
`else
   assign bus.o_m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: cycle table for latency/drain, directed backpressure,
// random backpressure scoreboard, async reset mid-burst and packet last-beat marking.
module tb_fifo_stream_reader;
   localparam int unsigned DW   = 48;
   localparam int          PKT  = 4;
   localparam int          NSRC = 2048;
   localparam int          NVEC = 17;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_stream_reader_if #(.D_WIDTH(DW)) bus ();
   logic [1:0] buf_cnt;

   fifo_stream_reader #(.D_WIDTH(DW), .PKT_LEN(PKT)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .bus       (bus),
      .o_buf_cnt (buf_cnt)
   );

   // FIFO model: words live in src[n_popped .. n_avail-1], data returned one cycle after a pop.
   logic [DW-1:0] src [NSRC];
   logic [DW-1:0] fifo_data = '0;
   int            n_avail   = 0;
   int            n_popped  = 0;
   logic          last_pop  = 1'b0;
   logic          m_ready   = 1'b0;

   assign bus.i_fifo_empty = (n_popped >= n_avail);
   assign bus.i_fifo_data  = fifo_data;
   assign bus.i_m_ready    = m_ready;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_popped <= n_avail;
         last_pop <= 1'b0;
      end else begin
         last_pop <= bus.o_fifo_rd_en;
         if (bus.o_fifo_rd_en) begin
            fifo_data <= src[n_popped % NSRC];
            n_popped  <= n_popped + 1;
         end
      end
   end

   int            n_cmp  = 0;
   int            n_err  = 0;
   int            n_out  = 0;
   int            n_beat = 0;
   int            n_last = 0;
   logic [DW-1:0] next_val = 48'd1;

   typedef struct {
      int            push;
      logic          ready;
      logic          rd_en;
      logic          valid;
      logic [DW-1:0] data;
      logic [1:0]    cnt;
   } vec_t;

   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [DW-1:0] val);
      src[n_avail % NSRC] = val;
      n_avail++;
   endtask

   // Per-cycle scoreboard, sampled mid-cycle: order, occupancy model, pop legality, last flag.
   task automatic monitor();
      logic exp_last;
      if (rst_n) begin
         check("rd_en_while_empty", 64'(bus.o_fifo_rd_en & bus.i_fifo_empty), 64'd0);
         check("buf_cnt_model", 64'(buf_cnt), 64'(n_popped - int'(last_pop) - n_out));
`ifdef FIFO_RD_LAST_EN
         exp_last = bus.o_m_valid && ((n_beat % PKT) == PKT - 1);
`else
         exp_last = 1'b0;
`endif
         check("m_last", 64'(bus.o_m_last), 64'(exp_last));
         if (bus.o_m_valid && m_ready) begin
            check("stream_data", 64'(bus.o_m_data), 64'(src[n_out % NSRC]));
            if (bus.o_m_last) n_last++;
            n_out++;
            n_beat++;
         end
      end else begin
         n_out  = n_popped;
         n_beat = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cycles, input logic rnd);
      int c = 0;
      while (!(n_out == n_avail && !bus.o_m_valid) && c < max_cycles) begin
         if (rnd) m_ready = 1'($urandom_range(0, 1));
         tick();
         c++;
      end
      check("drain_done", 64'(n_out == n_avail && !bus.o_m_valid), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t, expected < 1ms", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int            base;
      int            pushed;
      int            k;
      int            last0;
      logic          found;
      logic [DW-1:0] word0;

      // Test 1: 8 words, ready=1 (rows 0..11); test 4: single word (rows 12..16).
      vecs[0]  = '{8, 1'b1, 1'b1, 1'b0, 48'd0, 2'd0};
      vecs[1]  = '{0, 1'b1, 1'b1, 1'b0, 48'd0, 2'd0};
      vecs[2]  = '{0, 1'b1, 1'b1, 1'b1, 48'd1, 2'd1};
      vecs[3]  = '{0, 1'b1, 1'b1, 1'b1, 48'd2, 2'd1};
      vecs[4]  = '{0, 1'b1, 1'b1, 1'b1, 48'd3, 2'd1};
      vecs[5]  = '{0, 1'b1, 1'b1, 1'b1, 48'd4, 2'd1};
      vecs[6]  = '{0, 1'b1, 1'b1, 1'b1, 48'd5, 2'd1};
      vecs[7]  = '{0, 1'b1, 1'b1, 1'b1, 48'd6, 2'd1};
      vecs[8]  = '{0, 1'b1, 1'b0, 1'b1, 48'd7, 2'd1};
      vecs[9]  = '{0, 1'b1, 1'b0, 1'b1, 48'd8, 2'd1};
      vecs[10] = '{0, 1'b1, 1'b0, 1'b0, 48'd0, 2'd0};
      vecs[11] = '{0, 1'b1, 1'b0, 1'b0, 48'd0, 2'd0};
      vecs[12] = '{1, 1'b1, 1'b1, 1'b0, 48'd0, 2'd0};
      vecs[13] = '{0, 1'b1, 1'b0, 1'b0, 48'd0, 2'd0};
      vecs[14] = '{0, 1'b1, 1'b0, 1'b1, 48'd9, 2'd1};
      vecs[15] = '{0, 1'b1, 1'b0, 1'b0, 48'd0, 2'd0};
      vecs[16] = '{0, 1'b1, 1'b0, 1'b0, 48'd0, 2'd0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_rd_en", 64'(bus.o_fifo_rd_en), 64'd0);
      check("rst_valid", 64'(bus.o_m_valid), 64'd0);
      check("rst_data",  64'(bus.o_m_data), 64'd0);
      check("rst_last",  64'(bus.o_m_last), 64'd0);
      check("rst_cnt",   64'(buf_cnt), 64'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < NVEC; i++) begin
         for (int j = 0; j < vecs[i].push; j++) begin
            push(next_val);
            next_val++;
         end
         m_ready = vecs[i].ready;
         @(negedge clk);
         check($sformatf("vec%0d_rd_en", i), 64'(bus.o_fifo_rd_en), 64'(vecs[i].rd_en));
         check($sformatf("vec%0d_valid", i), 64'(bus.o_m_valid), 64'(vecs[i].valid));
         check($sformatf("vec%0d_cnt", i), 64'(buf_cnt), 64'(vecs[i].cnt));
         if (vecs[i].valid)
            check($sformatf("vec%0d_data", i), 64'(bus.o_m_data), 64'(vecs[i].data));
         monitor();
         @(posedge clk);
         #1;
      end

      // Test 2: backpressure with 10 words queued
      m_ready = 1'b0;
      base    = n_popped;
      word0   = 48'h100;
      for (int j = 0; j < 10; j++) push(48'h100 + DW'(j));
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.o_m_valid) check("t2_hold_data", 64'(bus.o_m_data), 64'(word0));
      end
      check("t2_pops", 64'(n_popped - base), 64'd3);
      check("t2_cnt", 64'(buf_cnt), 64'd3);
      check("t2_rd_en_stopped", 64'(bus.o_fifo_rd_en), 64'd0);
      m_ready = 1'b1;
      drain(200, 1'b0);

      // Test 3: 1000 random words, bursty FIFO fill, random ready
      pushed = 0;
      while (pushed < 1000) begin
         if ($urandom_range(0, 9) < 4) begin
            k = int'($urandom_range(1, 4));
            if (k > 1000 - pushed) k = 1000 - pushed;
            for (int j = 0; j < k; j++) push(DW'({$urandom(), $urandom()}));
            pushed += k;
         end
         m_ready = 1'($urandom_range(0, 1));
         tick();
      end
      drain(6000, 1'b1);

      // Test 5: async reset with two words buffered and one in flight
      m_ready = 1'b0;
      for (int j = 0; j < 5; j++) push(48'h500 + DW'(j));
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         tick();
         if (buf_cnt == 2'd2) found = 1'b1;
      end
      check("t5_reached_cnt2", 64'(found), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("t5_rd_en", 64'(bus.o_fifo_rd_en), 64'd0);
      check("t5_valid", 64'(bus.o_m_valid), 64'd0);
      check("t5_data",  64'(bus.o_m_data), 64'd0);
      check("t5_last",  64'(bus.o_m_last), 64'd0);
      check("t5_cnt",   64'(buf_cnt), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int j = 0; j < 6; j++) push(48'hA00 + DW'(j));
      m_ready = 1'b1;
      drain(100, 1'b0);

      // Test 6: 12 beats after a fresh reset, last marks beats 3, 7, 11
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      last0 = n_last;
      for (int j = 0; j < 12; j++) push(48'hC00 + DW'(j));
      drain(400, 1'b1);
`ifdef FIFO_RD_LAST_EN
      check("t6_last_count", 64'(n_last - last0), 64'd3);
`else
      check("t6_last_count", 64'(n_last - last0), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
